elevator_car_model: RTL and testbench
=====================================

ELEVATOR_CAR_MODEL -- requirements
Module: elevator_car_model

Interface
REQ-001 Parameter FLOORS, default 8, number of floors; floor index 0..FLOORS-1.
REQ-002 Parameter FLOOR_TICKS, default 4, engine-active cycles to travel one floor.
REQ-003 Parameter DOOR_TICKS, default 3, cycles for a full door open or close stroke.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock; all state changes on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 engine  in  2  00 stop, 01 up, 10 down, 11 treated as stop.
REQ-008 door  in  2  00 hold, 01 open, 10 close, 11 treated as hold.
REQ-009 floor  out  3  last floor the car was aligned with.
REQ-010 at_floor  out  1  car aligned with floor (travel counter zero).
REQ-011 sensor_up  out  1  top limit: floor==FLOORS-1 and at_floor.
REQ-012 sensor_down  out  1  bottom limit: floor==0 and at_floor.
REQ-013 sensor_door  out  1  door fully closed.
REQ-014 door_state  out  2  00 CLOSED, 01 OPENING, 10 OPEN, 11 CLOSING.
REQ-015 arrive  out  1  one-cycle pulse when floor changes.
REQ-016 fault  out  1  sticky until reset; illegal command seen.

Function
REQ-017 Travel counter cnt (0..FLOOR_TICKS-1) and dir register hold motion state; all outputs registered.
REQ-018 Engine up, door CLOSED, not at top limit: cnt increments each cycle; at cnt==FLOOR_TICKS-1 next cycle floor+1, cnt=0, arrive=1.
REQ-019 Engine down, door CLOSED, not at bottom limit: same counting; on completion floor-1, cnt=0, arrive=1.
REQ-020 Engine reversal while cnt!=0: cnt clears to 0 that cycle, floor unchanged, no arrive (model returns to last floor).
REQ-021 Engine stop with cnt!=0: cnt and dir hold; at_floor stays 0; resuming same direction continues count.
REQ-022 Engine up at sensor_up, or down at sensor_down: no motion, fault set.
REQ-023 Engine non-stop while door_state!=CLOSED: no motion, fault set.
REQ-024 Door FSM: CLOSED--open & at_floor & engine stop-->OPENING; OPENING--DOOR_TICKS cycles-->OPEN; OPEN--close-->CLOSING; CLOSING--DOOR_TICKS cycles-->CLOSED.
REQ-025 Open while CLOSING: immediate reversal to OPENING, timer restarts at 0.
REQ-026 Close while OPENING: ignored; stroke completes to OPEN.
REQ-027 Open when not at_floor or engine non-stop: ignored, fault set.
REQ-028 sensor_door=1 only in CLOSED; deasserts the cycle OPENING is entered.
REQ-029 Simultaneous engine non-stop and door open in CLOSED: engine wins if legal, door open ignored, fault set.

Reset
REQ-030 Reset values: floor=0, cnt=0, dir=up, door_state=CLOSED, at_floor=1, sensor_down=1, sensor_up=0, sensor_door=1, arrive=0, fault=0.
REQ-031 Reset asserted mid-travel or mid-stroke overrides all inputs that cycle; no arrive pulse emitted.

Structure
REQ-032 Shared package elevator_pkg holds engine encodings, door command encodings, door_state encodings; shared with elevator controller.
REQ-033 Door FSM and stroke timer in sub-module elevator_door_model; travel counter and limits in top.

Verification (FLOORS=8, FLOOR_TICKS=4, DOOR_TICKS=3)
REQ-034 Reset, engine=01 for 28 cycles -> arrive pulses every 4 cycles, floor 0->7, sensor_up=1, sensor_down=0, fault=0.
REQ-035 At floor 7, engine=01 one cycle -> floor stays 7, fault=1.
REQ-036 At floor 3, door=01 -> OPENING next cycle, OPEN 3 cycles later, sensor_door=0; engine=10 while OPEN -> no motion, fault=1.
REQ-037 Door CLOSING cycle 2, door=01 -> OPENING, OPEN 3 cycles later.
REQ-038 Engine=01 2 cycles, stop 5 cycles, 01 2 cycles -> floor 0->1 with exactly one arrive; at_floor=0 during stop.
REQ-039 Engine=01 2 cycles then 10 -> cnt clears, floor 0 held, no arrive; reset mid-travel -> REQ-030 values next cycle.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared encodings for the elevator car model and its controller.
// Engine, door command and door state values.
package elevator_pkg;

  typedef enum logic [1:0] {
    ENG_STOP = 2'b00,
    ENG_UP   = 2'b01,
    ENG_DOWN = 2'b10,
    ENG_RSVD = 2'b11
  } engine_e;

  typedef enum logic [1:0] {
    DOOR_HOLD  = 2'b00,
    DOOR_OPEN  = 2'b01,
    DOOR_CLOSE = 2'b10,
    DOOR_RSVD  = 2'b11
  } door_cmd_e;

  typedef enum logic [1:0] {
    DS_CLOSED  = 2'b00,
    DS_OPENING = 2'b01,
    DS_OPEN    = 2'b10,
    DS_CLOSING = 2'b11
  } door_state_e;

endpackage

// File: rtl/elevator_door_model.sv
// Door FSM with stroke timer for the elevator car model.
// Opening is only accepted with the car aligned and the engine stopped.
module elevator_door_model
  import elevator_pkg::*;
#(
  parameter int DOOR_TICKS = 3,
  localparam int TW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] door_i,
  input  logic       at_floor_i,
  input  logic       eng_stop_i,
  output logic [1:0] state_o,
  output logic       open_fault_o
);

  door_state_e   state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          cmd_open;
  logic          cmd_close;
  logic          open_ok;
  logic          tmr_done;

  assign cmd_open  = (door_i == DOOR_OPEN);
  assign cmd_close = (door_i == DOOR_CLOSE);
  assign open_ok   = at_floor_i && eng_stop_i;
  assign tmr_done  = (tmr_q == TW'(DOOR_TICKS - 1));
  assign state_o   = state_q;

  // Next door state, stroke timer and illegal-open flag
  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    open_fault_o = cmd_open && !open_ok;
    unique case (state_q)
      DS_CLOSED: begin
        if (cmd_open && open_ok) begin
          state_d = DS_OPENING;
          tmr_d   = '0;
        end
      end
      DS_OPENING: begin
        if (tmr_done) begin
          state_d = DS_OPEN;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      DS_OPEN: begin
        if (cmd_close) begin
          state_d = DS_CLOSING;
          tmr_d   = '0;
        end
      end
      DS_CLOSING: begin
        if (cmd_open && open_ok) begin
          state_d = DS_OPENING;
          tmr_d   = '0;
        end else if (tmr_done) begin
          state_d = DS_CLOSED;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: begin
        state_d = DS_CLOSED;
        tmr_d   = '0;
      end
    endcase
  end

  // Door state and timer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DS_CLOSED;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

endmodule

// File: rtl/elevator_car_model.sv
// Elevator car plant model: travel counter, floor tracking, limits.
// Door behaviour lives in elevator_door_model.
module elevator_car_model
  import elevator_pkg::*;
#(
  parameter int FLOORS      = 8,
  parameter int FLOOR_TICKS = 4,
  parameter int DOOR_TICKS  = 3,
  localparam int FW = (FLOORS > 1) ? $clog2(FLOORS) : 1,
  localparam int CW = (FLOOR_TICKS > 1) ? $clog2(FLOOR_TICKS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    engine,
  input  logic [1:0]    door,
  output logic [FW-1:0] floor,
  output logic          at_floor,
  output logic          sensor_up,
  output logic          sensor_down,
  output logic          sensor_door,
  output logic [1:0]    door_state,
  output logic          arrive,
  output logic          fault
);

  logic [FW-1:0] floor_q, floor_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic          arrive_q, arrive_d;
  logic          fault_q, fault_d;
  logic          eng_up, eng_dn, eng_stop;
  logic          aligned, top_lim, bot_lim;
  logic          door_closed, door_fault, eng_fault;
  logic [1:0]    ds_w;

  assign eng_up      = (engine == ENG_UP);
  assign eng_dn      = (engine == ENG_DOWN);
  assign eng_stop    = !(eng_up || eng_dn);
  assign aligned     = (cnt_q == '0);
  assign top_lim     = aligned && (floor_q == FW'(FLOORS - 1));
  assign bot_lim     = aligned && (floor_q == '0);
  assign door_closed = (ds_w == DS_CLOSED);

  assign floor       = floor_q;
  assign at_floor    = aligned;
  assign sensor_up   = top_lim;
  assign sensor_down = bot_lim;
  assign sensor_door = door_closed;
  assign door_state  = ds_w;
  assign arrive      = arrive_q;
  assign fault       = fault_q;

  elevator_door_model #(
    .DOOR_TICKS(DOOR_TICKS)
  ) u_door (
    .clk         (clk),
    .reset       (reset),
    .door_i      (door),
    .at_floor_i  (aligned),
    .eng_stop_i  (eng_stop),
    .state_o     (ds_w),
    .open_fault_o(door_fault)
  );

  // Travel: count toward next floor, reversal snaps back, faults block motion
  always_comb begin
    floor_d   = floor_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    arrive_d  = 1'b0;
    eng_fault = 1'b0;
    if (!eng_stop) begin
      if (!door_closed || (eng_up && top_lim) || (eng_dn && bot_lim)) begin
        eng_fault = 1'b1;
      end else if (!aligned && (dir_q != eng_up)) begin
        cnt_d = '0;
        dir_d = eng_up;
      end else begin
        dir_d = eng_up;
        if (cnt_q == CW'(FLOOR_TICKS - 1)) begin
          cnt_d    = '0;
          arrive_d = 1'b1;
          floor_d  = eng_up ? floor_q + 1'b1 : floor_q - 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
    fault_d = fault_q || eng_fault || door_fault;
  end

  // Motion and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      floor_q  <= '0;
      cnt_q    <= '0;
      dir_q    <= 1'b1;
      arrive_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      floor_q  <= floor_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      arrive_q <= arrive_d;
      fault_q  <= fault_d;
    end
  end

endmodule

// File: tb/tb_elevator_car_model.sv
// Self-checking bench for elevator_car_model.
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_elevator_car_model;

  localparam int NF = 8;
  localparam int FT = 4;
  localparam int DT = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] engine;
  logic [1:0] door;
  logic [2:0] floor;
  logic       at_floor;
  logic       sensor_up;
  logic       sensor_down;
  logic       sensor_door;
  logic [1:0] door_state;
  logic       arrive;
  logic       fault;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model: floor, ticks travelled, direction (+1/-1),
  // door phase 0..3 and remaining stroke cycles
  int m_fl, m_prog, m_dir, m_door, m_left;
  bit m_arr, m_fault;

  always #5 clk = ~clk;

  elevator_car_model #(
    .FLOORS(NF), .FLOOR_TICKS(FT), .DOOR_TICKS(DT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .engine     (engine),
    .door       (door),
    .floor      (floor),
    .at_floor   (at_floor),
    .sensor_up  (sensor_up),
    .sensor_down(sensor_down),
    .sensor_door(sensor_door),
    .door_state (door_state),
    .arrive     (arrive),
    .fault      (fault)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic [1:0] e, input logic [1:0] d,
                       input logic r);
    bit up, dn, moving, at, ok, efault, dfault;
    int want;
    if (r) begin
      m_fl = 0; m_prog = 0; m_dir = 1; m_door = 0; m_left = 0;
      m_arr = 0; m_fault = 0;
      return;
    end
    up     = (e == 2'd1);
    dn     = (e == 2'd2);
    moving = up || dn;
    at     = (m_prog == 0);
    ok     = at && !moving;
    efault = moving && (m_door != 0 || (up && at && m_fl == NF - 1) ||
                        (dn && at && m_fl == 0));
    dfault = (d == 2'd1) && !ok;
    m_arr  = 0;
    if (moving && !efault) begin
      want = up ? 1 : -1;
      if (m_prog != 0 && want != m_dir) begin
        m_prog = 0;
      end else begin
        m_prog++;
        if (m_prog == FT) begin
          m_fl  += want;
          m_prog = 0;
          m_arr  = 1;
        end
      end
      m_dir = want;
    end
    case (m_door)
      0: if (d == 2'd1 && ok) begin m_door = 1; m_left = DT; end
      1: begin m_left--; if (m_left == 0) m_door = 2; end
      2: if (d == 2'd2) begin m_door = 3; m_left = DT; end
      default: begin
        if (d == 2'd1 && ok) begin
          m_door = 1; m_left = DT;
        end else begin
          m_left--;
          if (m_left == 0) m_door = 0;
        end
      end
    endcase
    m_fault = m_fault || efault || dfault;
  endtask

  task automatic step(input logic [1:0] e, input logic [1:0] d,
                      input logic r);
    engine = e;
    door   = d;
    reset  = r;
    @(posedge clk);
    model(e, d, r);
    #1;
    chk("floor", floor, m_fl);
    chk("at_floor", at_floor, m_prog == 0);
    chk("sensor_up", sensor_up, m_prog == 0 && m_fl == NF - 1);
    chk("sensor_down", sensor_down, m_prog == 0 && m_fl == 0);
    chk("sensor_door", sensor_door, m_door == 0);
    chk("door_state", door_state, m_door);
    chk("arrive", arrive, m_arr);
    chk("fault", fault, m_fault);
  endtask

  initial begin
    int arr_cnt;
    logic [1:0] e, d;
    logic r;
    int hold;

    step(2'd0, 2'd0, 1'b1);
    chk("rst_floor", floor, 0);
    chk("rst_at_floor", at_floor, 1);
    chk("rst_sensor_down", sensor_down, 1);
    chk("rst_sensor_up", sensor_up, 0);
    chk("rst_sensor_door", sensor_door, 1);
    chk("rst_door_state", door_state, 0);
    chk("rst_arrive", arrive, 0);
    chk("rst_fault", fault, 0);

    arr_cnt = 0;
    for (int i = 0; i < 28; i++) begin
      step(2'd1, 2'd0, 1'b0);
      if (arrive) arr_cnt++;
      chk("arrive_period", arrive, (i % 4) == 3);
    end
    chk("run_arrivals", arr_cnt, 7);
    chk("run_top_floor", floor, 7);
    chk("run_sensor_up", sensor_up, 1);
    chk("run_sensor_down", sensor_down, 0);
    chk("run_fault", fault, 0);

    step(2'd1, 2'd0, 1'b0);
    chk("top_hold_floor", floor, 7);
    chk("top_fault", fault, 1);

    step(2'd0, 2'd0, 1'b1);
    for (int i = 0; i < 12; i++) step(2'd1, 2'd0, 1'b0);
    chk("at_floor3", floor, 3);
    step(2'd0, 2'd1, 1'b0);
    chk("opening", door_state, 1);
    chk("opening_sdoor", sensor_door, 0);
    step(2'd0, 2'd0, 1'b0);
    step(2'd0, 2'd2, 1'b0);
    chk("close_ignored", door_state, 1);
    step(2'd0, 2'd0, 1'b0);
    chk("open_reached", door_state, 2);
    step(2'd2, 2'd0, 1'b0);
    chk("open_nomove_fl", floor, 3);
    chk("open_nomove_at", at_floor, 1);
    chk("open_move_fault", fault, 1);

    step(2'd0, 2'd2, 1'b0);
    chk("closing", door_state, 3);
    step(2'd0, 2'd0, 1'b0);
    step(2'd0, 2'd1, 1'b0);
    chk("reopen", door_state, 1);
    for (int i = 0; i < 3; i++) step(2'd0, 2'd0, 1'b0);
    chk("reopen_open", door_state, 2);

    step(2'd0, 2'd0, 1'b1);
    arr_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      step((i >= 2 && i < 7) ? 2'd0 : 2'd1, 2'd0, 1'b0);
      if (arrive) arr_cnt++;
      if (i >= 2 && i < 7) chk("stop_at_floor", at_floor, 0);
    end
    chk("resume_floor", floor, 1);
    chk("resume_arrivals", arr_cnt, 1);
    chk("resume_fault", fault, 0);

    step(2'd0, 2'd0, 1'b1);
    step(2'd1, 2'd0, 1'b0);
    step(2'd1, 2'd0, 1'b0);
    step(2'd2, 2'd0, 1'b0);
    chk("rev_at_floor", at_floor, 1);
    chk("rev_floor", floor, 0);
    chk("rev_arrive", arrive, 0);
    step(2'd1, 2'd0, 1'b0);
    step(2'd1, 2'd0, 1'b0);
    step(2'd1, 2'd0, 1'b1);
    chk("midrst_floor", floor, 0);
    chk("midrst_at_floor", at_floor, 1);
    chk("midrst_arrive", arrive, 0);

    e = 2'd0;
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        e    = 2'($urandom_range(0, 3));
        hold = $urandom_range(1, 12);
      end
      hold--;
      case ($urandom_range(0, 9))
        0:       d = 2'd1;
        1:       d = 2'd2;
        2:       d = 2'd3;
        default: d = 2'd0;
      endcase
      if ($urandom_range(0, 3) == 0) e = 2'd0;
      r = ($urandom_range(0, 249) == 0);
      step(e, d, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
